// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-side push arbiter.
// Arbiter state encoding and index-width helper.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BURST
  } arb_state_t;

  function automatic int ARB_IDW(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_picker.sv
// Rotate-priority encoder: first set request at or after base.
// Scan wraps modulo NREQ; idx falls back to base when nothing is set.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]          req,
  input  logic [ARB_IDW(NREQ)-1:0] base,
  output logic [ARB_IDW(NREQ)-1:0] idx,
  output logic                     any
);

  localparam int IW = ARB_IDW(NREQ);

  logic [IW:0] pos;

  // Walk from the farthest slot back to base so the nearest request wins.
  always_comb begin
    idx = base;
    any = 1'b0;
    pos = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, base} + (IW + 1)'(k);
      if (pos >= (IW + 1)'(NREQ)) begin
        pos = pos - (IW + 1)'(NREQ);
      end
      if (req[pos[IW-1:0]]) begin
        idx = pos[IW-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port among NREQ requesters.
// Grants bounded bursts and never pushes while the FIFO is full.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 2
) (
  input  logic                     wclk,
  input  logic                     reset_w_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     full,
  output logic                     push,
  output logic [DW-1:0]            wdata,
  output logic [ARB_IDW(NREQ)-1:0] grant_id,
  output logic                     busy
);

  localparam int IW = ARB_IDW(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [IW-1:0] ID_LAST = IW'(NREQ - 1);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [CW-1:0] burst_cnt;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [IW-1:0] sel;
  logic          sel_vld;
  logic [CW-1:0] cnt_inc;

  function automatic logic [IW-1:0] nxt_id(input logic [IW-1:0] x);
    return (x == ID_LAST) ? '0 : x + IW'(1);
  endfunction

  rr_picker #(
    .NREQ (NREQ)
  ) u_pick (
    .req  (req_valid),
    .base (ptr),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Burst owner is locked; otherwise the rotating scan decides.
  always_comb begin
    sel     = pick_idx;
    sel_vld = pick_any;
    if (state == ARB_BURST) begin
      sel     = owner;
      sel_vld = req_valid[owner];
    end
  end

  assign cnt_inc = burst_cnt + CNT_ONE;

  // Handshake outputs are forced quiet while reset is held.
  always_comb begin
    req_ready = '0;
    push      = reset_w_n & sel_vld & ~full;
    grant_id  = reset_w_n ? sel : '0;
    req_ready[sel] = reset_w_n & ~full;
  end

  assign wdata = req_data[grant_id*DW +: DW];
  assign busy  = (state == ARB_BURST);

  // Arbiter FSM: open bursts on a push, close on quota or owner drop.
  always_ff @(posedge wclk or negedge reset_w_n) begin
    if (!reset_w_n) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (push) begin
            if (MAX_BURST == 1) begin
              ptr <= nxt_id(sel);
            end else begin
              owner     <= sel;
              burst_cnt <= CNT_ONE;
              state     <= ARB_BURST;
            end
          end
        end
        ARB_BURST: begin
          if (!req_valid[owner]) begin
            state     <= ARB_IDLE;
            ptr       <= nxt_id(owner);
            burst_cnt <= '0;
          end else if (!full) begin
            if (cnt_inc == CNT_MAX) begin
              state     <= ARB_IDLE;
              ptr       <= nxt_id(owner);
              burst_cnt <= '0;
            end else begin
              burst_cnt <= cnt_inc;
            end
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed scenarios plus random traffic.
// Three instances share one reset and are tracked by a quota-based model.
module tb_fifo_push_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  va, vb;
  logic [2:0]  vc;
  logic        fa, fb, fc;
  logic [31:0] da, db;
  logic [23:0] dc;

  logic [3:0] ra, rb;
  logic [2:0] rc;
  logic       pa, pb, pc;
  logic [7:0] wa, wb, wc;
  logic [1:0] ga, gb, gc;
  logic       ba, bb, bc;

  fifo_push_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(2)) u_a (
    .wclk(clk), .reset_w_n(rst_n), .req_valid(va), .req_data(da),
    .req_ready(ra), .full(fa), .push(pa), .wdata(wa),
    .grant_id(ga), .busy(ba));

  fifo_push_arbiter #(.NREQ(4), .DW(8), .MAX_BURST(1)) u_b (
    .wclk(clk), .reset_w_n(rst_n), .req_valid(vb), .req_data(db),
    .req_ready(rb), .full(fb), .push(pb), .wdata(wb),
    .grant_id(gb), .busy(bb));

  fifo_push_arbiter #(.NREQ(3), .DW(8), .MAX_BURST(3)) u_c (
    .wclk(clk), .reset_w_n(rst_n), .req_valid(vc), .req_data(dc),
    .req_ready(rc), .full(fc), .push(pc), .wdata(wc),
    .grant_id(gc), .busy(bc));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // own < 0 means no burst in progress; left = pushes still allowed.
  typedef struct {
    int ptr;
    int own;
    int left;
  } mst_t;

  localparam mst_t MRST = '{ptr: 0, own: -1, left: 0};

  mst_t ma, mb, mc;

  function automatic int msel(input mst_t s, input int n,
                              input logic [7:0] v);
    if (s.own >= 0) return s.own;
    for (int k = 0; k < n; k++) begin
      if (v[(s.ptr + k) % n]) return (s.ptr + k) % n;
    end
    return s.ptr;
  endfunction

  function automatic mst_t mnext(input mst_t s, input int n, input int mbst,
                                 input logic [7:0] v, input logic f);
    mst_t r;
    int   sel;
    r   = s;
    sel = msel(s, n, v);
    if (s.own < 0) begin
      if (v[sel] && !f) begin
        if (mbst == 1) begin
          r.ptr = (sel + 1) % n;
        end else begin
          r.own  = sel;
          r.left = mbst - 1;
        end
      end
    end else if (!v[s.own]) begin
      r.ptr = (s.own + 1) % n;
      r.own = -1;
    end else if (!f) begin
      r.left = r.left - 1;
      if (r.left == 0) begin
        r.ptr = (s.own + 1) % n;
        r.own = -1;
      end
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= MRST;
      mb <= MRST;
      mc <= MRST;
    end else begin
      ma <= mnext(ma, 4, 2, {4'b0, va}, fa);
      mb <= mnext(mb, 4, 1, {4'b0, vb}, fb);
      mc <= mnext(mc, 3, 3, {5'b0, vc}, fc);
    end
  end

  task automatic cmp(input string nm, input mst_t s, input int n,
                     input logic [7:0] v, input logic f, input logic [31:0] d,
                     input logic p, input logic [7:0] r, input logic [7:0] g,
                     input logic b, input logic [7:0] w);
    int         sel;
    logic [7:0] rexp;
    chk({nm, ".nopush_full"}, 32'(p & f), 32'd0);
    if (!rst_n) begin
      chk({nm, ".rst_push"}, 32'(p), 32'd0);
      chk({nm, ".rst_ready"}, 32'(r), 32'd0);
      chk({nm, ".rst_grant"}, 32'(g), 32'd0);
      chk({nm, ".rst_busy"}, 32'(b), 32'd0);
    end else begin
      sel  = msel(s, n, v);
      rexp = f ? 8'd0 : (8'd1 << sel);
      chk({nm, ".grant"}, 32'(g), 32'(sel));
      chk({nm, ".push"}, 32'(p), 32'(v[sel] & ~f));
      chk({nm, ".ready"}, 32'(r), 32'(rexp));
      chk({nm, ".busy"}, 32'(b), 32'(s.own >= 0));
      chk({nm, ".wdata"}, 32'(w), 32'(d[sel*8 +: 8]));
    end
  endtask

  bit run_cmp = 1'b0;

  // Every cycle, check all three instances against the model.
  always @(negedge clk) begin
    if (run_cmp) begin
      cmp("A", ma, 4, {4'b0, va}, fa, da, pa, {4'b0, ra}, {6'b0, ga}, ba, wa);
      cmp("B", mb, 4, {4'b0, vb}, fb, db, pb, {4'b0, rb}, {6'b0, gb}, bb, wb);
      cmp("C", mc, 3, {5'b0, vc}, fc, {8'b0, dc}, pc, {5'b0, rc},
          {6'b0, gc}, bc, wc);
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic lit_a(input string nm, input int g, input bit p,
                       input bit b);
    @(negedge clk);
    chk({nm, ".grant"}, 32'(ga), 32'(g));
    chk({nm, ".push"}, 32'(pa), 32'(p));
    chk({nm, ".busy"}, 32'(ba), 32'(b));
  endtask

  int gseq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
  bit bseq[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};

  initial begin
    rst_n = 1'b0;
    va = 4'hF; vb = '0; vc = '0;
    fa = 1'b0; fb = 1'b0; fc = 1'b0;
    da = 32'h4433_2211; db = 32'h8877_6655; dc = 24'hCC_BBAA;
    run_cmp = 1'b1;

    @(negedge clk);
    chk("reset.push", 32'(pa), 32'd0);
    chk("reset.ready", 32'(ra), 32'd0);
    chk("reset.grant", 32'(ga), 32'd0);
    nxt();
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      lit_a($sformatf("burst%0d", i), gseq[i], 1'b1, bseq[i]);
      nxt();
    end
    chk("burst.wdata", 32'(wa), 32'h11);

    rst_pulse();
    va = 4'b0100;
    lit_a("drop.first", 2, 1'b1, 1'b0);
    nxt();
    va = 4'b1001;
    lit_a("drop.gap", 2, 1'b0, 1'b1);
    nxt();
    lit_a("drop.next", 3, 1'b1, 1'b0);
    nxt();

    rst_pulse();
    va = 4'b0010;
    lit_a("stall.first", 1, 1'b1, 1'b0);
    nxt();
    fa = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lit_a("stall.hold", 1, 1'b0, 1'b1);
      chk("stall.ready", 32'(ra), 32'd0);
      nxt();
    end
    fa = 1'b0;
    va = 4'b0110;
    lit_a("stall.last", 1, 1'b1, 1'b1);
    nxt();
    lit_a("stall.rot", 2, 1'b1, 1'b0);
    nxt();

    rst_pulse();
    va = 4'b0100;
    lit_a("mid.first", 2, 1'b1, 1'b0);
    nxt();
    lit_a("mid.burst", 2, 1'b1, 1'b1);
    nxt();
    va = 4'b0101;
    rst_pulse();
    lit_a("mid.after", 0, 1'b1, 1'b0);
    nxt();

    va = '0;
    rst_pulse();
    vb = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mb1.grant3", 32'(gb), 32'd3);
      chk("mb1.push", 32'(pb), 32'd1);
      chk("mb1.busy", 32'(bb), 32'd0);
      nxt();
    end
    vb = 4'b1001;
    @(negedge clk);
    chk("mb1.wrap", 32'(gb), 32'd0);
    nxt();

    for (int i = 0; i < 3000; i++) begin
      va = 4'($urandom);
      vb = 4'($urandom);
      vc = 3'($urandom);
      fa = ($urandom_range(3) == 0);
      fb = ($urandom_range(3) == 0);
      fc = ($urandom_range(4) == 0);
      da = $urandom;
      db = $urandom;
      dc = 24'($urandom);
      if ($urandom_range(150) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      nxt();
    end
    rst_n = 1'b1;
    nxt();
    run_cmp = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
